// File: rtl/rcv_pkg.sv
// Shared types for the receive FIFO controller.
// RCV_FIFO_ERR_TAG_EN widens each FIFO entry with an overrun tag bit.
package rcv_pkg;

  localparam int RCV_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } rcv_ctrl_state_t;

`ifdef RCV_FIFO_ERR_TAG_EN
  typedef struct packed {
    logic                  err;
    logic [RCV_BYTE_W-1:0] data;
  } rcv_entry_t;
`else
  typedef struct packed {
    logic [RCV_BYTE_W-1:0] data;
  } rcv_entry_t;
`endif

endpackage

// File: rtl/rcv_fifo_mem.sv
// Register-array storage for the receive FIFO: one write port and an
// asynchronous (show-ahead) read port.
module rcv_fifo_mem
  import rcv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  rcv_entry_t    wdata,
  input  logic [AW-1:0] raddr,
  output rcv_entry_t    rdata
);

  rcv_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rcv_fifo_ctrl.sv
// Receive-side controller: acknowledges rcv_block bytes into a show-ahead FIFO
// and counts framing-error packets. RCV_FIFO_ERR_TAG_EN enables the overrun tag.
module rcv_fifo_ctrl
  import rcv_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ready,
  input  logic [RCV_BYTE_W-1:0] rx_data,
  input  logic                  framing_error,
  input  logic                  overrun_error,
  output logic                  data_read,
  input  logic                  pop,
  output logic [RCV_BYTE_W-1:0] rd_data,
  output logic                  rd_err,
  output logic                  empty,
  output logic                  full,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]     drop_cnt,
  output rcv_ctrl_state_t       fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: a byte is offered while data_ready is high; it is taken at the
  // edge where IDLE sees data_ready && !full, data_read pulses the next cycle,
  // and the FSM then waits for data_ready to drop before taking another byte.
  rcv_ctrl_state_t state, state_nxt;
  logic [AW-1:0]   wptr, rptr;
  logic            push, pop_ok, fe_q;
  rcv_entry_t      wentry, rentry;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign fsm_state = state;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    data_read = 1'b0;
    case (state)
      IDLE: begin
        if (data_ready && !full) begin
          push      = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        data_read = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (!data_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      fe_q     <= 1'b0;
      drop_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (push)   wptr <= wptr + 1'b1;
      if (pop_ok) rptr <= rptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      fe_q <= framing_error;
      // Rising edges only; the counter sticks at all-ones.
      if (framing_error && !fe_q && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

`ifdef RCV_FIFO_ERR_TAG_EN
  assign wentry = '{err: overrun_error, data: rx_data};
  assign rd_err = !empty && rentry.err;
`else
  logic unused_overrun;
  assign unused_overrun = overrun_error;
  assign wentry = '{data: rx_data};
  assign rd_err = 1'b0;
`endif

  assign rd_data = empty ? '0 : rentry.data;

  rcv_fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (push),
    .waddr(wptr),
    .wdata(wentry),
    .raddr(rptr),
    .rdata(rentry)
  );

endmodule

// File: tb/tb_rcv_fifo_ctrl.sv
// Bench for rcv_fifo_ctrl: directed rcv_block-style sequences plus random
// traffic, checked every cycle against a queue-based reference model.
module tb_rcv_fifo_ctrl;
  import rcv_pkg::*;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef RCV_FIFO_ERR_TAG_EN
  localparam bit TAG = 1'b1;
`else
  localparam bit TAG = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       data_ready = 1'b0;
  logic [7:0] rx_data = 8'd0;
  logic       framing_error = 1'b0;
  logic       overrun_error = 1'b0;
  logic       pop = 1'b0;

  logic            data_read, rd_err, empty, full;
  logic [7:0]      rd_data, drop_cnt;
  logic [CW-1:0]   count;
  rcv_ctrl_state_t fsm_state;

  logic            data_read2, rd_err2, empty2, full2;
  logic [7:0]      rd_data2;
  logic [1:0]      drop_cnt2;
  logic [CW-1:0]   count2;
  rcv_ctrl_state_t fsm_state2;

  rcv_fifo_ctrl #(.DEPTH(DEPTH), .DROP_W(8)) u_dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .rx_data(rx_data),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read), .pop(pop), .rd_data(rd_data), .rd_err(rd_err),
    .empty(empty), .full(full), .count(count), .drop_cnt(drop_cnt),
    .fsm_state(fsm_state)
  );

  rcv_fifo_ctrl #(.DEPTH(DEPTH), .DROP_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .data_ready(data_ready), .rx_data(rx_data),
    .framing_error(framing_error), .overrun_error(overrun_error),
    .data_read(data_read2), .pop(pop), .rd_data(rd_data2), .rd_err(rd_err2),
    .empty(empty2), .full(full2), .count(count2), .drop_cnt(drop_cnt2),
    .fsm_state(fsm_state2)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: byte queue plus handshake flags
  logic [8:0] exp_q[$];
  bit         m_ack, m_wait, m_fe_q, started;
  bit         was_full, was_empty;
  int         m_edges;
  logic [8:0] head;

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      exp_q.delete();
      m_ack   = 1'b0;
      m_wait  = 1'b0;
      m_fe_q  = 1'b0;
      m_edges = 0;
    end else begin
      was_full  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (framing_error && !m_fe_q) m_edges++;
      m_fe_q = framing_error;
      if (pop && !was_empty) void'(exp_q.pop_front());
      if (m_ack) begin
        m_ack  = 1'b0;
        m_wait = 1'b1;
      end else if (m_wait) begin
        if (!data_ready) m_wait = 1'b0;
      end else if (data_ready && !was_full) begin
        exp_q.push_back({TAG & overrun_error, rx_data});
        m_ack = 1'b1;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (started) begin
      head = (exp_q.size() != 0) ? exp_q[0] : 9'd0;
      chk("data_read", 32'(data_read), 32'(m_ack));
      chk("count",     32'(count),     32'(exp_q.size()));
      chk("empty",     32'(empty),     32'(exp_q.size() == 0));
      chk("full",      32'(full),      32'(exp_q.size() == DEPTH));
      chk("rd_data",   32'(rd_data),   32'(head[7:0]));
      chk("rd_err",    32'(rd_err),    32'(head[8]));
      chk("drop_cnt",  32'(drop_cnt),  32'((m_edges > 255) ? 255 : m_edges));
      chk("drop_cnt_w2", 32'(drop_cnt2), 32'((m_edges > 3) ? 3 : m_edges));
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (!data_read && n < 200) begin
      tick();
      n++;
    end
    if (!data_read) chk("ack_timeout", 32'd0, 32'd1);
  endtask

  // rcv_block-style delivery: hold data_ready until acknowledged, drop it a cycle later
  task automatic send_byte(input logic [7:0] b, input logic ov);
    data_ready    = 1'b1;
    rx_data       = b;
    overrun_error = ov;
    tick();
    wait_ack();
    tick();
    data_ready    = 1'b0;
    overrun_error = 1'b0;
    repeat ($urandom_range(2, 6)) tick();
  endtask

  task automatic pop_one();
    pop = 1'b1;
    tick();
    pop = 1'b0;
  endtask

  task automatic bad_packet();
    framing_error = 1'b1;
    repeat (2) tick();
    framing_error = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_rd_data",   32'(rd_data),   32'd0);
    chk("rst_data_read", 32'(data_read), 32'd0);
    chk("rst_drop",      32'(drop_cnt),  32'd0);

    // single byte
    tick();
    send_byte(8'hD5, 1'b0);
    @(negedge clk);
    chk("d5_count",  32'(count),   32'd1);
    chk("d5_data",   32'(rd_data), 32'hD5);
    chk("d5_err",    32'(rd_err),  32'd0);
    tick();
    pop_one();
    @(negedge clk);
    chk("d5_empty",  32'(empty),   32'd1);

    // fill, hold a byte while full, then drain in order
    tick();
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
    @(negedge clk);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_full",  32'(full),  32'd1);
    tick();
    data_ready = 1'b1;
    rx_data    = 8'h09;
    repeat (4) tick();
    chk("held_no_ack", 32'(data_read), 32'd0);
    rx_data       = 8'h0A;
    overrun_error = 1'b1;
    repeat (2) tick();
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      chk("pop_order", 32'(rd_data), 32'(i));
      tick();
      pop_one();
    end
    data_ready    = 1'b0;
    overrun_error = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("held_data",  32'(rd_data), 32'h0A);
    chk("held_err",   32'(rd_err),  32'(TAG));
    chk("held_count", 32'(count),   32'd1);
    tick();
    pop_one();

    // framing-error packets and saturation of the narrow counter
    repeat (3) bad_packet();
    @(negedge clk);
    chk("drop3",       32'(drop_cnt), 32'd3);
    chk("drop3_count", 32'(count),    32'd0);
    tick();
    repeat (2) bad_packet();
    @(negedge clk);
    chk("drop5",     32'(drop_cnt),  32'd5);
    chk("drop5_sat", 32'(drop_cnt2), 32'd3);

    // push and pop in the same cycle at count 4, then pop while empty
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h40 + i), 1'b0);
    data_ready = 1'b1;
    rx_data    = 8'h44;
    pop        = 1'b1;
    tick();
    pop = 1'b0;
    @(negedge clk);
    chk("pushpop_count", 32'(count),   32'd4);
    chk("pushpop_head",  32'(rd_data), 32'h41);
    tick();
    data_ready = 1'b0;
    repeat (3) tick();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("pushpop_order", 32'(rd_data), 32'(8'h40 + i));
      tick();
      pop_one();
    end
    pop = 1'b1;
    repeat (3) tick();
    pop = 1'b0;
    @(negedge clk);
    chk("empty_pop_count", 32'(count), 32'd0);
    chk("empty_pop_empty", 32'(empty), 32'd1);

    // reset during ACK with five entries; the held byte is taken again
    tick();
    for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i), 1'b0);
    data_ready = 1'b1;
    rx_data    = 8'h64;
    tick();
    wait_ack();
    chk("pre_rst_count", 32'(count), 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_count", 32'(count),     32'd0);
    chk("post_rst_ack",   32'(data_read), 32'd0);
    tick();
    wait_ack();
    tick();
    data_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("recap_count", 32'(count),   32'd1);
    chk("recap_data",  32'(rd_data), 32'h64);
    tick();
    pop_one();

    // random traffic, alternating pop-heavy and push-heavy phases
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) data_ready = ~data_ready;
      rx_data       = 8'($urandom);
      overrun_error = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) framing_error = ~framing_error;
      pop = ($urandom_range(0, 9) < (((c / 500) % 2 == 1) ? 2 : 6));
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst        = 1'b0;
    pop        = 1'b0;
    data_ready = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
